// File: rtl/csa25_rr_arbiter.sv
// csa25_rr_arbiter: round-robin sharing of one 25-bit carry-select adder
// among NUM_REQ valid/ready requesters, with one registered response stage.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge) and async active-low reset
//   i_req_valid        per-requester valid
//   i_req_a, i_req_b   packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready        one-hot grant, gated by response-stage space
//   o_rsp_valid/sum/cout/id  registered result and winning requester
//   i_rsp_ready        downstream accepts the response
//   o_busy             response pending or any request outstanding

// csa_25bit: combinational 25-bit carry-select adder, five 5-bit blocks.
// Each block precomputes its sum for carry-in 0 and 1, and the incoming
// carry picks one, so the critical path is one block plus a mux chain.
module csa_25bit (
    input  logic [24:0] a,
    input  logic [24:0] b,
    input  logic        cin,
    output logic [24:0] sum,
    output logic        cout
);

    localparam int BLK  = 5;
    localparam int NBLK = 5;

    logic [NBLK:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;

        assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign s1 = s0 + (BLK+1)'(1);

        assign sum[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[g+1]            = c[g] ? s1[BLK]     : s0[BLK];
    end

    assign cout = c[NBLK];

endmodule

module csa25_rr_arbiter #(
    parameter int WIDTH   = 25,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_rsp_valid,
    output logic [WIDTH-1:0]         o_rsp_sum,
    output logic                     o_rsp_cout,
    output logic [ID_W-1:0]          o_rsp_id,
    input  logic                     i_rsp_ready,
    output logic                     o_busy
);

    // Elaboration-time parameter guards
    if (WIDTH != 25) begin : g_bad_width
        $error("csa25_rr_arbiter: WIDTH must be 25");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("csa25_rr_arbiter: NUM_REQ must be 2..8");
    end
    if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
        $error("csa25_rr_arbiter: ID_W too narrow for NUM_REQ");
    end

    // Pointer resets to the top index so requester 0 wins first.
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win;
    logic               found;
    int                 idx;

    logic               load_ok;
    logic               accept;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // The response register can take a new result when empty or draining.
    assign load_ok = !o_rsp_valid || i_rsp_ready;

    // Rotating priority search, starting just after the last winner.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = ID_W'(idx);
            end
        end
    end

    // Ready depends only on valids, pointer and load_ok; held low in reset.
    assign o_req_ready = (i_rst_n && load_ok) ? grant : '0;
    assign accept      = |o_req_ready;

    // win is 0 with no grant, so requester 0 drives the don't-care case.
    assign add_a = i_req_a[int'(win)*WIDTH +: WIDTH];
    assign add_b = i_req_b[int'(win)*WIDTH +: WIDTH];

    csa_25bit u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_sum   <= '0;
            o_rsp_cout  <= 1'b0;
            o_rsp_id    <= '0;
            last_grant  <= PTR_RST;
        end else if (accept) begin
            // New result overwrites any result draining this same edge.
            o_rsp_valid <= 1'b1;
            o_rsp_sum   <= add_sum;
            o_rsp_cout  <= add_cout;
            o_rsp_id    <= win;
            last_grant  <= win;
        end else if (o_rsp_valid && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

    assign o_busy = o_rsp_valid || (|i_req_valid);

endmodule
